ram_dp_param: RTL and testbench

Parametrised, single-clock, true dual-port RAM for program/data memory in the MSP430 subsystem. It is the next generation of the fixed 16-bit dual-port wrappers, and adds:

- configurable data width, depth and read latency;
- per-byte write enables;
- a defined read/write collision policy;
- a post-reset hardware clear sequencer that fills the array with a known value before accepting accesses.

Both ports use the low-active `cen`/`wen` convention of the existing RAM models.

---
 rtl/ram_dp_pkg.sv | 38 +++
 rtl/ram_dp_init_fsm.sv | 56 +++++
 rtl/ram_dp_param.sv | 163 ++++++++++++++++
 tb/tb_ram_dp_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_pkg.sv
// ram_dp_pkg
//   Types and helpers shared by the parametrised dual-port RAM and its
//   clear sequencer.
//   - coll_mode_e  : same-address read-during-write policy
//   - init_state_e : clear sequencer states
//   - byte_merge() : lane-wise merge of a new word over an old one, sized to
//                    MAX_DW so any DATA_WIDTH up to MAX_DW can use it
package ram_dp_pkg;

  // Widest word byte_merge() can handle; callers pad to this width.
  localparam int MAX_DW = 128;
  localparam int MAX_NB = MAX_DW / 8;

  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } coll_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } init_state_e;

  // Lanes whose mask bit is set take new_word, the rest keep old_word.
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_word,
    input logic [MAX_DW-1:0] new_word,
    input logic [MAX_NB-1:0] lane_mask
  );
    logic [MAX_DW-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_NB; i++) begin
      if (lane_mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_dp_init_fsm.sv
// ram_dp_init_fsm
//   Post-reset clear sequencer. After puc_rst it walks the word address
//   from 0 to DEPTH-1, one word per cycle, then parks in READY until the
//   next reset. A reset mid-clear restarts the walk from 0.
// Ports
//   mclk      in   clock, rising edge
//   puc_rst   in   synchronous active-high reset
//   init_busy out  high while clearing (registered)
//   clr_we    out  clear write strobe for the array (registered)
//   clr_addr  out  word address being cleared (registered)
module ram_dp_init_fsm #(
  parameter int DEPTH = 2048,
  parameter int IW    = 11
) (
  input  logic          mclk,
  input  logic          puc_rst,
  output logic          init_busy,
  output logic          clr_we,
  output logic [IW-1:0] clr_addr
);
  import ram_dp_pkg::*;

  localparam logic [IW-1:0] LAST_ADDR = IW'(DEPTH - 1);
  localparam logic [IW-1:0] ADDR_ONE  = IW'(1);

  init_state_e   r_state;
  logic [IW-1:0] r_clr_addr;
  logic          r_busy;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clr_addr == LAST_ADDR) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end else begin
            r_clr_addr <= r_clr_addr + ADDR_ONE;
          end
        end
        READY: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy = r_busy;
  assign clr_we    = r_busy;
  assign clr_addr  = r_clr_addr;

endmodule

// File: rtl/ram_dp_param.sv
// ram_dp_param
//   Single-clock true dual-port RAM with per-byte write enables,
//   configurable read latency, a same-address collision policy and a
//   post-reset clear of the whole array to INIT_VALUE.
// Ports (x = a or b, identical ports, cen/wen low active)
//   mclk, puc_rst      clock and synchronous active-high reset
//   ram_cenx           chip enable
//   ram_wenx[NB]       byte write enables, bit i -> bits [8i+7:8i]
//   ram_addrx          word address
//   ram_dinx           write data
//   ram_doutx          read data, valid READ_LATENCY edges after access
//   init_busy          high while the clear sequence runs
//   wr_collision       one-cycle pulse after both ports wrote one address
module ram_dp_param #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_MSB     = 10,
  parameter int                    MEM_SIZE     = 4096,
  parameter int                    READ_LATENCY = 1,
  parameter int                    COLL_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    ram_cena,
  input  logic [DATA_WIDTH/8-1:0] ram_wena,
  input  logic [ADDR_MSB:0]       ram_addra,
  input  logic [DATA_WIDTH-1:0]   ram_dina,
  output logic [DATA_WIDTH-1:0]   ram_douta,
  input  logic                    ram_cenb,
  input  logic [DATA_WIDTH/8-1:0] ram_wenb,
  input  logic [ADDR_MSB:0]       ram_addrb,
  input  logic [DATA_WIDTH-1:0]   ram_dinb,
  output logic [DATA_WIDTH-1:0]   ram_doutb,
  output logic                    init_busy,
  output logic                    wr_collision
);
  import ram_dp_pkg::*;

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = MEM_SIZE / NB;
  localparam int AW    = ADDR_MSB + 1;
  localparam int AWP   = AW + 1;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AWP-1:0] DEPTH_V = AWP'(DEPTH);
  localparam coll_mode_e MODE = (COLL_MODE == 1) ? READ_FIRST : WRITE_FIRST;

  // Pads to the package width so byte_merge() serves any DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] merge_w(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         mask
  );
    logic [MAX_DW-1:0] p_old, p_new, p_res;
    logic [MAX_NB-1:0] p_mask;
    p_old  = '0;
    p_new  = '0;
    p_mask = '0;
    p_old[DATA_WIDTH-1:0] = old_word;
    p_new[DATA_WIDTH-1:0] = new_word;
    p_mask[NB-1:0]        = mask;
    p_res = byte_merge(p_old, p_new, p_mask);
    return p_res[DATA_WIDTH-1:0];
  endfunction

  logic                  w_init_busy;
  logic                  w_clr_we;
  logic [IW-1:0]         w_clr_addr;
  logic                  w_ready;
  logic                  w_act_a, w_act_b;
  logic                  w_inr_a, w_inr_b;
  logic                  w_same;
  logic [IW-1:0]         w_idx_a, w_idx_b;
  logic [NB-1:0]         w_wr_a, w_wr_b;
  logic [DATA_WIDTH-1:0] w_old_a, w_old_b;
  logic [DATA_WIDTH-1:0] w_new_a, w_new_b;
  logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;

  logic [DATA_WIDTH-1:0] r_s1_a, r_s1_b, r_s2_a, r_s2_b;
  logic                  r_ld_a, r_ld_b;
  logic                  r_coll;

  ram_dp_init_fsm #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_init (
    .mclk      (mclk),
    .puc_rst   (puc_rst),
    .init_busy (w_init_busy),
    .clr_we    (w_clr_we),
    .clr_addr  (w_clr_addr)
  );

  // The reset cycle itself is also treated as busy so an access cannot
  // slip in while the sequencer is being restarted.
  assign w_ready = ~w_init_busy & ~puc_rst;
  assign w_act_a = w_ready & ~ram_cena;
  assign w_act_b = w_ready & ~ram_cenb;
  assign w_inr_a = ({1'b0, ram_addra} < DEPTH_V);
  assign w_inr_b = ({1'b0, ram_addrb} < DEPTH_V);
  assign w_idx_a = ram_addra[IW-1:0];
  assign w_idx_b = ram_addrb[IW-1:0];
  assign w_same  = (ram_addra == ram_addrb);
  // Out-of-range writes are dropped by folding the range check into the
  // lane masks, which also keeps them out of the collision detect.
  assign w_wr_a  = {NB{w_act_a & w_inr_a}} & ~ram_wena;
  assign w_wr_b  = {NB{w_act_b & w_inr_b}} & ~ram_wenb;

  // One narrow array per byte lane gives natural byte-enable writes.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] r_mem [0:DEPTH-1];

    always_ff @(posedge mclk) begin
      if (w_clr_we && !puc_rst) begin
        r_mem[w_clr_addr] <= INIT_VALUE[8*gi +: 8];
      end else begin
        // Port A is written last so it wins on an overlapping lane.
        if (w_wr_b[gi]) r_mem[w_idx_b] <= ram_dinb[8*gi +: 8];
        if (w_wr_a[gi]) r_mem[w_idx_a] <= ram_dina[8*gi +: 8];
      end
    end

    assign w_old_a[8*gi +: 8] = w_inr_a ? r_mem[w_idx_a] : 8'h00;
    assign w_old_b[8*gi +: 8] = w_inr_b ? r_mem[w_idx_b] : 8'h00;
  end

  // Word as it will stand after this edge: B's lanes first, then A's on
  // top, matching the commit order above.
  assign w_new_a = merge_w(merge_w(w_old_a, ram_dinb, w_wr_b & {NB{w_same}}),
                           ram_dina, w_wr_a);
  assign w_new_b = merge_w(merge_w(w_old_b, ram_dinb, w_wr_b),
                           ram_dina, w_wr_a & {NB{w_same}});

  assign w_rd_a = (MODE == READ_FIRST) ? w_old_a : w_new_a;
  assign w_rd_b = (MODE == READ_FIRST) ? w_old_b : w_new_b;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_s1_a <= '0;
      r_s1_b <= '0;
      r_s2_a <= '0;
      r_s2_b <= '0;
      r_ld_a <= 1'b0;
      r_ld_b <= 1'b0;
      r_coll <= 1'b0;
    end else begin
      r_ld_a <= w_act_a;
      r_ld_b <= w_act_b;
      if (w_act_a) r_s1_a <= w_rd_a;
      if (w_act_b) r_s1_b <= w_rd_b;
      // Second stage only advances behind a real first-stage load.
      if (r_ld_a) r_s2_a <= r_s1_a;
      if (r_ld_b) r_s2_b <= r_s1_b;
      r_coll <= w_same & (|(w_wr_a & w_wr_b));
    end
  end

  assign ram_douta    = (READ_LATENCY == 2) ? r_s2_a : r_s1_a;
  assign ram_doutb    = (READ_LATENCY == 2) ? r_s2_b : r_s1_b;
  assign init_busy    = w_init_busy;
  assign wr_collision = r_coll;

endmodule

// File: tb/tb_ram_dp_param.sv
// Two instances share one stimulus stream: WRITE_FIRST with latency 1 and
// READ_FIRST with latency 2. A behavioural model predicts every output
// after every edge and queues it; a negedge monitor pops and compares.
module tb_ram_dp_param;

  localparam int          DEPTH = 64;
  localparam logic [15:0] INIT  = 16'hA5A5;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        cena, cenb;
  logic [1:0]  wena, wenb;
  logic [10:0] addra, addrb;
  logic [15:0] dina, dinb;
  logic [15:0] douta_wf, doutb_wf, douta_rf, doutb_rf;
  logic        busy_wf, busy_rf, coll_wf, coll_rf;

  always #5 mclk = ~mclk;

  ram_dp_param #(.DATA_WIDTH(16), .ADDR_MSB(10), .MEM_SIZE(128),
                 .READ_LATENCY(1), .COLL_MODE(0), .INIT_VALUE(INIT)) dut_wf (
    .mclk(mclk), .puc_rst(puc_rst),
    .ram_cena(cena), .ram_wena(wena), .ram_addra(addra), .ram_dina(dina), .ram_douta(douta_wf),
    .ram_cenb(cenb), .ram_wenb(wenb), .ram_addrb(addrb), .ram_dinb(dinb), .ram_doutb(doutb_wf),
    .init_busy(busy_wf), .wr_collision(coll_wf));

  ram_dp_param #(.DATA_WIDTH(16), .ADDR_MSB(10), .MEM_SIZE(128),
                 .READ_LATENCY(2), .COLL_MODE(1), .INIT_VALUE(INIT)) dut_rf (
    .mclk(mclk), .puc_rst(puc_rst),
    .ram_cena(cena), .ram_wena(wena), .ram_addra(addra), .ram_dina(dina), .ram_douta(douta_rf),
    .ram_cenb(cenb), .ram_wenb(wenb), .ram_addrb(addrb), .ram_dinb(dinb), .ram_doutb(doutb_rf),
    .init_busy(busy_rf), .wr_collision(coll_rf));

  typedef struct {
    int          due;
    logic [15:0] wa, wb, ra, rb;
    logic        coll, busy;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_no = 0;

  // Reference state
  logic [15:0] mdl_mem [DEPTH];
  bit          mdl_busy = 1'b1;
  int          clr_left = 0;
  logic [15:0] e_wf_a = '0, e_wf_b = '0, e_rf_a = '0, e_rf_b = '0;
  bit          pend_a = 1'b0, pend_b = 1'b0;
  logic [15:0] pend_va = '0, pend_vb = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, edge_no, act, req);
    end
  endtask

  function automatic logic [15:0] lane_wr(input logic [15:0] v, input logic [15:0] d,
                                          input logic [1:0] wen);
    for (int i = 0; i < 2; i++) if (!wen[i]) v[8*i +: 8] = d[8*i +: 8];
    return v;
  endfunction

  // One clock edge: drive, clock, then advance the model and queue the
  // outputs it expects to see after this edge.
  task automatic step(input bit rst,
                      input bit ca, input logic [1:0] wa, input logic [10:0] aa, input logic [15:0] da,
                      input bit cb, input logic [1:0] wb, input logic [10:0] ab, input logic [15:0] db);
    bit acc, act_a, act_b, inr_a, inr_b, wr_a, wr_b, coll;
    logic [15:0] old_a, old_b, aft_a, aft_b;
    exp_t e;
    puc_rst = rst; cena = ca; wena = wa; addra = aa; dina = da;
    cenb = cb; wenb = wb; addrb = ab; dinb = db;
    @(posedge mclk);
    #1;
    edge_no++;
    acc   = !rst && !mdl_busy;
    inr_a = int'(aa) < DEPTH;
    inr_b = int'(ab) < DEPTH;
    old_a = inr_a ? mdl_mem[aa[5:0]] : 16'h0000;
    old_b = inr_b ? mdl_mem[ab[5:0]] : 16'h0000;
    act_a = acc && !ca;
    act_b = acc && !cb;
    wr_a  = act_a && inr_a && (wa != 2'b11);
    wr_b  = act_b && inr_b && (wb != 2'b11);
    aft_a = old_a;
    if (wr_b && ab == aa) aft_a = lane_wr(aft_a, db, wb);
    if (wr_a)             aft_a = lane_wr(aft_a, da, wa);
    aft_b = old_b;
    if (wr_b)             aft_b = lane_wr(aft_b, db, wb);
    if (wr_a && aa == ab) aft_b = lane_wr(aft_b, da, wa);
    coll = wr_a && wr_b && (aa == ab) && ((~wa & ~wb) != 2'b00);
    if (rst) begin
      e_wf_a = '0; e_wf_b = '0; e_rf_a = '0; e_rf_b = '0;
      pend_a = 1'b0; pend_b = 1'b0;
      mdl_busy = 1'b1;
      clr_left = DEPTH;
    end else begin
      if (pend_a) e_rf_a = pend_va;
      if (pend_b) e_rf_b = pend_vb;
      pend_a = act_a; pend_va = old_a;
      pend_b = act_b; pend_vb = old_b;
      if (act_a) e_wf_a = aft_a;
      if (act_b) e_wf_b = aft_b;
      if (wr_b) mdl_mem[ab[5:0]] = lane_wr(mdl_mem[ab[5:0]], db, wb);
      if (wr_a) mdl_mem[aa[5:0]] = lane_wr(mdl_mem[aa[5:0]], da, wa);
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) begin
          mdl_busy = 1'b0;
          for (int k = 0; k < DEPTH; k++) mdl_mem[k] = INIT;
        end
      end
    end
    e.due = edge_no; e.wa = e_wf_a; e.wb = e_wf_b; e.ra = e_rf_a; e.rb = e_rf_b;
    e.coll = coll; e.busy = mdl_busy;
    sb_q.push_back(e);
    $display("edge %0d rst=%0b A: cen=%0b wen=%b addr=%0d din=%h | B: cen=%0b wen=%b addr=%0d din=%h",
             edge_no, rst, ca, wa, aa, da, cb, wb, ab, db);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 2'b11, 11'd0, 16'h0, 1'b1, 2'b11, 11'd0, 16'h0);
  endtask

  function automatic logic [10:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return 11'($urandom_range(60, 71));
    return 11'($urandom_range(0, 7));
  endfunction

  task automatic rnd_step();
    step(1'b0, ($urandom_range(0, 3) == 0), 2'($urandom), rnd_addr(), 16'($urandom),
               ($urandom_range(0, 3) == 0), 2'($urandom), rnd_addr(), 16'($urandom));
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge mclk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_due",   edge_no,  e.due);
        chk("douta_wf", douta_wf, e.wa);
        chk("doutb_wf", doutb_wf, e.wb);
        chk("douta_rf", douta_rf, e.ra);
        chk("doutb_rf", doutb_rf, e.rb);
        chk("coll_wf",  coll_wf,  e.coll);
        chk("coll_rf",  coll_rf,  e.coll);
        chk("busy_wf",  busy_wf,  e.busy);
        chk("busy_rf",  busy_rf,  e.busy);
      end
    end
  end

  initial begin
    int busy_cnt;
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 2'b11, 11'd0, 16'h0, 1'b1, 2'b11, 11'd0, 16'h0);
    // Accesses during the clear are ignored; reset again at cycle 20.
    for (int i = 0; i < 20; i++) rnd_step();
    step(1'b1, 1'b1, 2'b11, 11'd0, 16'h0, 1'b1, 2'b11, 11'd0, 16'h0);
    @(negedge mclk);
    busy_cnt = busy_wf ? 1 : 0;
    for (int i = 0; i < 66; i++) begin
      if (i < 60) rnd_step(); else idle();
      @(negedge mclk);
      if (busy_wf) busy_cnt++;
    end
    chk("busy_len", busy_cnt, DEPTH);
    chk("hold_clear_a", douta_wf, 16'h0000);
    chk("hold_clear_b", doutb_rf, 16'h0000);

    // Cleared contents
    step(1'b0, 1'b0, 2'b11, 11'd0, 16'h0, 1'b0, 2'b11, 11'd31, 16'h0);
    @(negedge mclk);
    chk("clr_addr0", douta_wf, INIT);
    chk("clr_addr31", doutb_wf, INIT);
    step(1'b0, 1'b0, 2'b11, 11'd63, 16'h0, 1'b1, 2'b11, 11'd0, 16'h0);
    @(negedge mclk);
    chk("clr_addr63", douta_wf, INIT);

    // Byte lanes
    step(1'b0, 1'b0, 2'b00, 11'd5, 16'h1234, 1'b1, 2'b11, 11'd0, 16'h0);
    step(1'b0, 1'b0, 2'b01, 11'd5, 16'hFF00, 1'b1, 2'b11, 11'd0, 16'h0);
    step(1'b0, 1'b0, 2'b11, 11'd5, 16'h0000, 1'b1, 2'b11, 11'd0, 16'h0);
    @(negedge mclk);
    chk("byte_lane", douta_wf, 16'hFF34);

    // Cross-port read during write
    step(1'b0, 1'b0, 2'b00, 11'd9, 16'h0000, 1'b1, 2'b11, 11'd0, 16'h0);
    step(1'b0, 1'b0, 2'b11, 11'd9, 16'h0000, 1'b0, 2'b00, 11'd9, 16'hBEEF);
    @(negedge mclk);
    chk("xport_wf", douta_wf, 16'hBEEF);
    idle();
    @(negedge mclk);
    chk("xport_rf", douta_rf, 16'h0000);

    // Dual write, port A wins
    step(1'b0, 1'b0, 2'b00, 11'd3, 16'h1111, 1'b0, 2'b00, 11'd3, 16'h2222);
    @(negedge mclk);
    chk("coll_pulse", coll_wf, 1'b1);
    idle();
    @(negedge mclk);
    chk("coll_end", coll_wf, 1'b0);

    // Out of range
    step(1'b0, 1'b0, 2'b00, 11'd70, 16'h7777, 1'b1, 2'b11, 11'd0, 16'h0);
    step(1'b0, 1'b0, 2'b11, 11'd70, 16'h0000, 1'b0, 2'b11, 11'd6, 16'h0);
    @(negedge mclk);
    chk("oor_read", douta_wf, 16'h0000);
    chk("oor_addr6", doutb_wf, INIT);

    // Latency 2: value shows two edges after its access
    step(1'b0, 1'b0, 2'b11, 11'd3, 16'h0, 1'b1, 2'b11, 11'd0, 16'h0);
    step(1'b0, 1'b0, 2'b11, 11'd0, 16'h0, 1'b1, 2'b11, 11'd0, 16'h0);
    @(negedge mclk);
    chk("lat1_now", douta_wf, INIT);
    chk("lat2_prev", douta_rf, 16'h1111);
    idle();
    @(negedge mclk);
    chk("lat2_now", douta_rf, INIT);

    for (int i = 0; i < 300; i++) rnd_step();
    for (int i = 0; i < 3; i++) idle();
    @(negedge mclk);
    chk("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
